// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, bit rate, SPI mode
// (CPOL/CPHA) and up to NCS chip selects with optional multi-word frame hold.
// The CPU writes config or data through `in` and polls `out` for busy/result.
module spi_master_param #(
  parameter int WIDTH = 8,
  parameter int DIV   = 16,
  parameter int NCS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             cfg,
  input  logic [15:0]      in,
  output logic [15:0]      out,
  output logic             SDO,
  input  logic             SDI,
  output logic             SCK,
  output logic [NCS-1:0]   CSN
);

  localparam int             PW       = $clog2(2 * DIV);
  localparam logic [PW-1:0]  PH_PRE   = PW'(DIV - 1);
  localparam logic [PW-1:0]  PH_LEAD  = PW'(DIV);
  localparam logic [PW-1:0]  PH_LAST  = PW'(2 * DIV - 1);
  localparam logic [3:0]     BIT_LAST = 4'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   tx_q, tx_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [1:0]         mode_q, mode_d;
  logic [2:0]         sel_q, sel_d;
  logic               hold_q, hold_d;
  logic               sck_q, sck_d;
  logic               sdo_q, sdo_d;
  logic [NCS-1:0]     csn_q, csn_d;
  logic               wrap_s;
  logic               unused_in_s;

  // Pull the selected line low; a select beyond the populated lines asserts nothing.
  function automatic logic [NCS-1:0] csn_select(input logic [NCS-1:0] cur,
                                                input logic [2:0]     sel);
    logic [NCS-1:0] r;
    r = cur;
    for (int i = 0; i < NCS; i++) begin
      if (int'(sel) == i) r[i] = 1'b0;
    end
    return r;
  endfunction

  assign wrap_s      = (phase_q == PH_LAST);
  assign unused_in_s = ^in[15:7];

  // Next-state logic: config writes, transfer start, bit timing, shifting and frame end.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    res_d    = res_q;
    bitcnt_d = bitcnt_q;
    phase_d  = phase_q;
    mode_d   = mode_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    csn_d    = csn_q;
    sdo_d    = sdo_q;

    case (state_q)
      S_IDLE: begin
        sdo_d = 1'b0;
        if (cfg) begin
          // cfg wins over a simultaneous load
          mode_d = in[1:0];
          sel_d  = in[4:2];
          hold_d = in[5];
          if (in[6]) csn_d = '1;
          else       csn_d = csn_q;
        end else if (load) begin
          state_d  = S_XFER;
          tx_d     = in[WIDTH-1:0];
          rx_d     = '0;
          bitcnt_d = 4'd0;
          phase_d  = '0;
          csn_d    = csn_select(csn_q, sel_q);
          // CPHA=1 presents the first bit only at the leading edge
          if (mode_q[0]) sdo_d = 1'b0;
          else           sdo_d = in[WIDTH-1];
        end else begin
          state_d = S_IDLE;
        end
      end

      S_XFER: begin
        if (wrap_s) phase_d = '0;
        else        phase_d = phase_q + PW'(1);

        // Sample SDI one cycle after the leading edge (CPHA=0) or at the end of the bit (CPHA=1)
        if (!mode_q[0] && (phase_q == PH_LEAD))   rx_d = {rx_q[WIDTH-2:0], SDI};
        else if (mode_q[0] && wrap_s)              rx_d = {rx_q[WIDTH-2:0], SDI};
        else                                       rx_d = rx_q;

        if (mode_q[0]) begin
          // CPHA=1: next bit appears together with the leading SCK edge
          if (phase_q == PH_PRE) begin
            sdo_d = tx_q[WIDTH-1];
            tx_d  = {tx_q[WIDTH-2:0], 1'b0};
          end else begin
            sdo_d = sdo_q;
          end
        end else begin
          // CPHA=0: next bit appears at the start of the bit period
          if (wrap_s) begin
            sdo_d = tx_q[WIDTH-2];
            tx_d  = {tx_q[WIDTH-2:0], 1'b0};
          end else begin
            sdo_d = sdo_q;
          end
        end

        if (wrap_s) begin
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == BIT_LAST) begin
            state_d  = S_IDLE;
            res_d    = rx_d;
            bitcnt_d = 4'd0;
            sdo_d    = 1'b0;
            if (!hold_q) csn_d = '1;
            else         csn_d = csn_q;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          bitcnt_d = bitcnt_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SCK follows the phase of the upcoming cycle so the pin itself is a register.
  always_comb begin
    sck_d = mode_d[1];
    if ((state_d == S_XFER) && (phase_d >= PH_LEAD)) sck_d = ~mode_d[1];
    else                                             sck_d = mode_d[1];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tx_q     <= '0;
      rx_q     <= '0;
      res_q    <= '0;
      bitcnt_q <= 4'd0;
      phase_q  <= '0;
      mode_q   <= 2'b00;
      sel_q    <= 3'b000;
      hold_q   <= 1'b0;
      sck_q    <= 1'b0;
      sdo_q    <= 1'b0;
      csn_q    <= '1;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      res_q    <= res_d;
      bitcnt_q <= bitcnt_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      hold_q   <= hold_d;
      sck_q    <= sck_d;
      sdo_q    <= sdo_d;
      csn_q    <= csn_d;
    end
  end

  // Status word: busy flag on top, last completed word in the low bits.
  always_comb begin
    out             = 16'h0000;
    out[15]         = (state_q == S_XFER);
    out[WIDTH-1:0]  = res_q;
  end

  assign SDO = sdo_q;
  assign SCK = sck_q;
  assign CSN = csn_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: a behavioural SPI slave and a
// cycle monitor provide the expected words, busy length, SCK edges and SDO phases.
module tb_spi_master_param;

  localparam int W_A = 8;
  localparam int D_A = 2;
  localparam int N_A = 4;
  localparam int W_B = 12;
  localparam int D_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n  = 1'b0;
  logic           load_a = 1'b0;
  logic           cfg_a  = 1'b0;
  logic [15:0]    in_a   = 16'h0000;
  logic [15:0]    out_a;
  logic           sdo_a, sck_a, sdi_a;
  logic [N_A-1:0] csn_a;
  logic           load_b = 1'b0;
  logic           cfg_b  = 1'b0;
  logic [15:0]    in_b   = 16'h0000;
  logic [15:0]    out_b;
  logic           sdo_b, sck_b;
  logic [0:0]     csn_b;

  logic           loopback = 1'b1;
  logic           slv_sdi  = 1'b0;
  logic [7:0]     slv_tx   = 8'h00;
  logic [7:0]     slv_rx   = 8'h00;
  logic [1:0]     tb_mode  = 2'b00;
  logic           frame_watch = 1'b0;
  logic           arm_frame   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int mon_len = 0, mon_edges = 0, mon_first_edge = 0, mon_sdo_bad = 0;
  int mon_csn_low = 0, mon_frame_bad = 0;
  logic prev_busy = 1'b0, prev_sck = 1'b0, prev_sdo = 1'b0;

  assign sdi_a = loopback ? sdo_a : slv_sdi;

  spi_master_param #(.WIDTH(W_A), .DIV(D_A), .NCS(N_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .cfg(cfg_a), .in(in_a), .out(out_a),
    .SDO(sdo_a), .SDI(sdi_a), .SCK(sck_a), .CSN(csn_a)
  );

  spi_master_param #(.WIDTH(W_B), .DIV(D_B), .NCS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .cfg(cfg_b), .in(in_b), .out(out_b),
    .SDO(sdo_b), .SDI(sdo_b), .SCK(sck_b), .CSN(csn_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor and SPI slave: watches SCK edges between clock edges, as a real slave would.
  always @(negedge clk) begin
    int   ph;
    logic leading;
    if (out_a[15] && !prev_busy) begin
      mon_len = 0; mon_edges = 0; mon_first_edge = 0; mon_sdo_bad = 0; mon_csn_low = 0;
    end
    if (out_a[15]) mon_len++;
    ph = (mon_len - 1) % (2 * D_A);
    if (out_a[15] || prev_busy) begin
      if (out_a[15] && (csn_a != 4'hF)) mon_csn_low++;
      if (sck_a != prev_sck) begin
        mon_edges++;
        if (mon_edges == 1) mon_first_edge = mon_len;
        leading = (prev_sck == tb_mode[1]);
        if (leading != tb_mode[0]) begin
          slv_rx = {slv_rx[6:0], prev_sdo};
        end else if (tb_mode[0]) begin
          slv_sdi = slv_tx[7];
          slv_tx  = slv_tx << 1;
        end else begin
          slv_tx  = slv_tx << 1;
          slv_sdi = slv_tx[7];
        end
      end
      if (out_a[15] && prev_busy && (sdo_a != prev_sdo) && (ph != (tb_mode[0] ? D_A : 0)))
        mon_sdo_bad++;
    end
    if (frame_watch && (csn_a != 4'b0111)) mon_frame_bad++;
    prev_busy = out_a[15];
    prev_sck  = sck_a;
    prev_sdo  = sdo_a;
  end

  task automatic cfg_write(input logic [15:0] v);
    in_a = v; cfg_a = 1'b1;
    tick();
    cfg_a = 1'b0;
    tb_mode = v[1:0];
  endtask

  // One transfer on dut_a; optionally injects a load (kind[0]) and/or cfg (kind[1]) mid-way.
  task automatic xfer_a(input logic [15:0] word, input logic [7:0] sword,
                        input logic [15:0] exp_out, input int inject_at, input logic [1:0] kind);
    int cnt;
    slv_tx = sword; slv_rx = 8'h00; slv_sdi = sword[7];
    in_a = word; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    frame_watch = arm_frame;
    cnt = 0;
    while (out_a[15] && (cnt < 2000)) begin
      cnt++;
      if (cnt == inject_at) begin
        in_a = 16'h00FF; load_a = kind[0]; cfg_a = kind[1];
      end else begin
        load_a = 1'b0; cfg_a = 1'b0;
      end
      tick();
    end
    load_a = 1'b0; cfg_a = 1'b0;
    if (cnt >= 2000) check("busy_timeout", {31'd0, out_a[15]}, 32'd0);
    check("busy_len",   mon_len, 2 * D_A * W_A);
    check("sck_edges",  mon_edges, 2 * W_A);
    check("first_edge", mon_first_edge, D_A + 1);
    check("sdo_phase",  mon_sdo_bad, 0);
    check("rx_word",    {16'd0, out_a}, {16'd0, exp_out});
    check("slave_rx",   {24'd0, slv_rx}, {24'd0, word[7:0]});
    check("sck_idle",   {31'd0, sck_a}, {31'd0, tb_mode[1]});
    check("sdo_idle",   {31'd0, sdo_a}, 32'd0);
  endtask

  task automatic xfer_b(input logic [11:0] word);
    int len;
    in_b = {4'h0, word}; load_b = 1'b1;
    tick();
    load_b = 1'b0;
    len = 0;
    while (out_b[15] && (len < 2000)) begin
      len++;
      tick();
    end
    check("b_busy_len", len, 2 * D_B * W_B);
    check("b_out", {16'd0, out_b}, {20'd0, word});
  endtask

  initial begin
    logic [7:0] w, s;
    int cnt;

    // Reset state
    tick(); tick();
    check("rst_out_a", {16'd0, out_a}, 32'd0);
    check("rst_sck",   {31'd0, sck_a}, 32'd0);
    check("rst_sdo",   {31'd0, sdo_a}, 32'd0);
    check("rst_csn",   {28'd0, csn_a}, 32'hF);
    check("rst_out_b", {16'd0, out_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Mode 0 loopback of 0xA5
    loopback = 1'b1;
    cfg_write(16'h0000);
    xfer_a(16'h00A5, 8'h00, 16'h00A5, 0, 2'b00);
    check("loop_csn_low", mon_csn_low, 2 * D_A * W_A);
    check("loop_csn_end", {28'd0, csn_a}, 32'hF);

    // All four modes against the slave model
    loopback = 1'b0;
    for (int m = 0; m < 4; m++) begin
      cfg_write(16'(m));
      check("mode_sck_pre", {31'd0, sck_a}, {31'd0, tb_mode[1]});
      xfer_a(16'h00C3, 8'h3C, 16'h003C, 0, 2'b00);
      for (int k = 0; k < 2; k++) begin
        w = 8'($urandom_range(0, 255));
        s = 8'($urandom_range(0, 255));
        xfer_a({8'h00, w}, s, {8'h00, s}, 0, 2'b00);
      end
    end

    // Multi-word frame on CSN[3] with hold, then release
    cfg_write(16'h002C);
    arm_frame = 1'b1; mon_frame_bad = 0;
    xfer_a(16'h0012, 8'h34, 16'h0034, 0, 2'b00);
    check("hold_csn_mid", {28'd0, csn_a}, 32'h7);
    xfer_a(16'h0056, 8'h78, 16'h0078, 0, 2'b00);
    arm_frame = 1'b0; frame_watch = 1'b0;
    check("frame_csn", mon_frame_bad, 0);
    check("hold_csn_end", {28'd0, csn_a}, 32'h7);
    cfg_write(16'h0040);
    check("release_csn", {28'd0, csn_a}, 32'hF);

    // Select beyond NCS: no chip select asserted
    cfg_write(16'h0014);
    xfer_a(16'h0099, 8'h66, 16'h0066, 0, 2'b00);
    check("nosel_csn_low", mon_csn_low, 0);

    // Requests while busy are ignored
    cfg_write(16'h0000);
    xfer_a(16'h005A, 8'h96, 16'h0096, 5, 2'b01);
    xfer_a(16'h00A3, 8'h4D, 16'h004D, 9, 2'b10);
    xfer_a(16'h0011, 8'hE2, 16'h00E2, 14, 2'b11);

    // Simultaneous load and cfg while idle: config taken, no transfer
    in_a = 16'h0003; load_a = 1'b1; cfg_a = 1'b1;
    tick();
    load_a = 1'b0; cfg_a = 1'b0; tb_mode = 2'b11;
    check("both_busy", {31'd0, out_a[15]}, 32'd0);
    check("both_sck",  {31'd0, sck_a}, 32'd1);
    xfer_a(16'h00C5, 8'hA7, 16'h00A7, 0, 2'b00);

    // Reset during bit 3 of a mode-3 transfer
    slv_tx = 8'h5B; slv_rx = 8'h00;
    in_a = 16'h0055; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    cnt = 0;
    while ((mon_len < 3 * 2 * D_A + 1) && (cnt < 2000)) begin
      cnt++;
      tick();
    end
    check("rst_reach_bit3", {31'd0, out_a[15]}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; tb_mode = 2'b00;
    check("mid_rst_busy", {31'd0, out_a[15]}, 32'd0);
    check("mid_rst_sck",  {31'd0, sck_a}, 32'd0);
    check("mid_rst_sdo",  {31'd0, sdo_a}, 32'd0);
    check("mid_rst_csn",  {28'd0, csn_a}, 32'hF);
    check("mid_rst_out",  {16'd0, out_a}, 32'd0);
    tick();

    // Wide, slower instance in loopback
    xfer_b(12'hABC);
    for (int k = 0; k < 2; k++) xfer_b(12'($urandom_range(0, 4095)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
